// File: rtl/stoch_signed_rev_unpatch_pkg.sv
// stoch_nnlib_pkg: shared unpatch state enum and tile-grid helper
package stoch_nnlib_pkg;
  typedef enum logic {FILL, HOLD} unpatch_state_t;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/stoch_signed_rev_unpatch_if.sv
// stoch_signed_rev_unpatch_if: tile input and frame output handshake bundle
interface stoch_signed_rev_unpatch_if #(
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 32,
  parameter int CHANNELS = 3,
  parameter int PATCH_W  = 3,
  parameter int PATCH_H  = 3
);
  logic in_valid;
  logic in_ready;
  logic [CHANNELS-1:0][PATCH_H-1:0][PATCH_W-1:0] patch_p;
  logic [CHANNELS-1:0][PATCH_H-1:0][PATCH_W-1:0] patch_m;
  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0] out_p;
  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0] out_m;
  logic out_valid;
  logic out_ack;
  logic frame_done;
  modport master (output in_valid, patch_p, patch_m, out_ack,
                  input in_ready, out_p, out_m, out_valid, frame_done);
  modport slave (input in_valid, patch_p, patch_m, out_ack,
                 output in_ready, out_p, out_m, out_valid, frame_done);
endinterface

// File: rtl/stoch_signed_rev_unpatch_tile_counter.sv
// stoch_tile_counter: raster tile_row/tile_col counter with advance, clear and last-tile flag
module stoch_tile_counter #(
  parameter int TILES_W = 11,
  parameter int TILES_H = 11,
  localparam int RW = $clog2(TILES_H + 1),
  localparam int CW = $clog2(TILES_W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          clr,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);
  logic [RW-1:0] row_d, row_q;
  logic [CW-1:0] col_d, col_q;
  logic          col_end;
  assign col_end = col_q == CW'(TILES_W - 1);
  assign last = col_end && row_q == RW'(TILES_H - 1);
  assign row = row_q;
  assign col = col_q;
  // column wraps each row; both wrap together after the last tile
  always_comb begin
    col_d = clr ? '0 : adv ? (col_end ? '0 : col_q + 1'b1) : col_q;
    row_d = clr ? '0 : (adv && col_end) ? (last ? '0 : row_q + 1'b1) : row_q;
  end
  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
endmodule

// File: rtl/stoch_signed_rev_unpatch.sv
// stoch_signed_rev_unpatch: scatters signed stochastic tiles into a double-buffered map; optional STOCH_UNPATCH_RESTART_EN adds restart
module stoch_signed_rev_unpatch
  import stoch_nnlib_pkg::*;
#(
  parameter int   WIDTH    = 32,
  parameter int   HEIGHT   = 32,
  parameter int   CHANNELS = 3,
  parameter int   PATCH_W  = 3,
  parameter int   PATCH_H  = 3,
  parameter logic DEFAULT  = 1'b0
) (
  input logic CLK,
  input logic nRST,
  stoch_signed_rev_unpatch_if.slave bus
`ifdef STOCH_UNPATCH_RESTART_EN
  , input logic restart
`endif
);
  localparam int TILES_W = ceil_div(WIDTH, PATCH_W);
  localparam int TILES_H = ceil_div(HEIGHT, PATCH_H);
  localparam int RW = $clog2(TILES_H + 1);
  localparam int CW = $clog2(TILES_W + 1);
  typedef logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0] map_t;
  map_t bank_p_d [2];
  map_t bank_p_q [2];
  map_t bank_m_d [2];
  map_t bank_m_q [2];
  unpatch_state_t state_d, state_q;
  logic sel_d, sel_q, out_valid_d, out_valid_q, frame_done_d, frame_done_q;
  logic clr, accept, last, swap;
  logic [RW-1:0] tile_row;
  logic [CW-1:0] tile_col;
  int orow, ocol;
`ifdef STOCH_UNPATCH_RESTART_EN
  assign clr = restart;
`else
  assign clr = 1'b0;
`endif
  assign bus.in_ready = state_q == FILL && !clr;
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_p = bank_p_q[sel_q];
  assign bus.out_m = bank_m_q[sel_q];
  assign bus.out_valid = out_valid_q;
  assign bus.frame_done = frame_done_q;
  stoch_tile_counter #(.TILES_W(TILES_W), .TILES_H(TILES_H)) u_cnt (
    .clk(CLK), .rst_n(nRST), .adv(accept), .clr(clr),
    .row(tile_row), .col(tile_col), .last(last)
  );
  // swap when a completed back bank meets a released (or never-claimed) front bank
  always_comb begin
    swap = !clr && (state_q == HOLD ? bus.out_ack
                                    : accept && last && (!out_valid_q || bus.out_ack));
    state_d = clr ? FILL
            : state_q == HOLD ? (bus.out_ack ? FILL : HOLD)
            : (accept && last && !swap) ? HOLD : FILL;
    sel_d = sel_q ^ swap;
    out_valid_d = swap || (out_valid_q && !bus.out_ack);
    frame_done_d = swap;
  end
  // scatter the accepted tile into the back bank, dropping pixels past the map edge
  always_comb begin
    bank_p_d = bank_p_q;
    bank_m_d = bank_m_q;
    orow = int'(tile_row) * PATCH_H;
    ocol = int'(tile_col) * PATCH_W;
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++)
        for (int r = 0; r < PATCH_H; r++)
          for (int c = 0; c < PATCH_W; c++)
            if (accept && y == orow + r && x == ocol + c)
              for (int ch = 0; ch < CHANNELS; ch++) begin
                bank_p_d[!sel_q][y][x][ch] = bus.patch_p[ch][r][c];
                bank_m_d[!sel_q][y][x][ch] = bus.patch_m[ch][r][c];
              end
  end
  // state, bank select and both map banks
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bank_p_q     <= '{default: {(HEIGHT*WIDTH*CHANNELS){DEFAULT}}};
      bank_m_q     <= '{default: {(HEIGHT*WIDTH*CHANNELS){DEFAULT}}};
      state_q      <= FILL;
      sel_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      bank_p_q     <= bank_p_d;
      bank_m_q     <= bank_m_d;
      state_q      <= state_d;
      sel_q        <= sel_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_stoch_signed_rev_unpatch.sv
// tb_stoch_signed_rev_unpatch: randomized tile streams checked against a frame-level model
module tb_stoch_signed_rev_unpatch;
  localparam int W = 5, H = 4, C = 2, PW = 2, PH = 2;
  localparam int TW = (W + PW - 1) / PW, TH = (H + PH - 1) / PH, NT = TW * TH;
  typedef logic [H-1:0][W-1:0][C-1:0] map_t;
  typedef logic [C-1:0][PH-1:0][PW-1:0] patch_t;
  logic CLK = 0, nRST = 0, restart = 0;
  int tests = 0, fails = 0;
  map_t mf_p, mf_m, mb_p, mb_m;
  int n;
  bit mhold, mvalid, mfd;
  stoch_signed_rev_unpatch_if #(.WIDTH(W), .HEIGHT(H), .CHANNELS(C), .PATCH_W(PW), .PATCH_H(PH)) bus();
  stoch_signed_rev_unpatch #(.WIDTH(W), .HEIGHT(H), .CHANNELS(C), .PATCH_W(PW), .PATCH_H(PH),
                             .DEFAULT(1'b0)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
`ifdef STOCH_UNPATCH_RESTART_EN
    , .restart(restart)
`endif
  );
  always #5 CLK = ~CLK;

  function automatic map_t put(map_t m, int k, patch_t p);
    for (int ch = 0; ch < C; ch++)
      for (int r = 0; r < PH; r++)
        for (int c = 0; c < PW; c++) begin
          int y, x;
          y = (k / TW) * PH + r;
          x = (k % TW) * PW + c;
          if (y < H && x < W) m[y][x][ch] = p[ch][r][c];
        end
    return m;
  endfunction

  task automatic model_reset();
    mf_p = '0; mf_m = '0; mb_p = '0; mb_m = '0;
    n = 0; mhold = 0; mvalid = 0; mfd = 0;
  endtask

  task automatic drive_tile(input bit v);
    bus.in_valid = v;
    bus.patch_p = patch_t'($urandom);
    bus.patch_m = patch_t'($urandom);
  endtask

  task automatic tick();
    bit acc, lst, sw, ack;
    map_t t;
    ack = bus.out_ack;
    acc = bus.in_valid && !mhold && !restart;
    lst = n == NT - 1;
    sw = !restart && (mhold ? ack : acc && lst && (!mvalid || ack));
    if (acc) begin
      mb_p = put(mb_p, n, bus.patch_p);
      mb_m = put(mb_m, n, bus.patch_m);
    end
    mhold = restart ? 0 : mhold ? !ack : (acc && lst && !sw);
    n = restart ? 0 : acc ? (lst ? 0 : n + 1) : n;
    mvalid = sw || (mvalid && !ack);
    mfd = sw;
    if (sw) begin
      t = mf_p; mf_p = mb_p; mb_p = t;
      t = mf_m; mf_m = mb_m; mb_m = t;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.out_ack = 0; bus.patch_p = '0; bus.patch_m = '0;
    nRST = 0;
    model_reset();
    #12;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    tests++; if (bus.out_p !== '0) begin fails++; $display("FAIL reset_out_p got %h want 0", bus.out_p); end
    tests++; if (bus.out_m !== '0) begin fails++; $display("FAIL reset_out_m got %h want 0", bus.out_m); end
    @(negedge CLK);
    nRST = 1;
  endtask

  task automatic test_fill();
    patch_t t5p;
    for (int k = 0; k < NT; k++) begin
      drive_tile(1);
      if (k == NT - 1) t5p = bus.patch_p;
      tick();
      tests++; if (bus.frame_done !== mfd) begin fails++; $display("FAIL fill_frame_done tile %0d got %b want %b", k, bus.frame_done, mfd); end
    end
    bus.in_valid = 0;
    tests++; if (bus.frame_done !== 1'b1) begin fails++; $display("FAIL fill_done_pulse got %b want 1", bus.frame_done); end
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL fill_out_valid got %b want 1", bus.out_valid); end
    tests++; if (bus.out_p !== mf_p) begin fails++; $display("FAIL fill_out_p got %h want %h", bus.out_p, mf_p); end
    tests++; if (bus.out_m !== mf_m) begin fails++; $display("FAIL fill_out_m got %h want %h", bus.out_m, mf_m); end
    tests++; if (bus.out_p[3][4][1] !== t5p[1][1][0]) begin fails++; $display("FAIL fill_corner got %b want %b", bus.out_p[3][4][1], t5p[1][1][0]); end
    tick();
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL fill_pulse_width got %b want 0", bus.frame_done); end
  endtask

  task automatic test_hold();
    map_t f1p;
    f1p = mf_p;
    for (int k = 0; k < NT + 2; k++) begin
      drive_tile(1);
      tick();
      tests++; if (bus.in_ready !== !mhold) begin fails++; $display("FAIL hold_in_ready step %0d got %b want %b", k, bus.in_ready, !mhold); end
    end
    bus.in_valid = 0;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL hold_state got %b want 0", bus.in_ready); end
    tests++; if (bus.out_p !== f1p) begin fails++; $display("FAIL hold_front got %h want %h", bus.out_p, f1p); end
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL hold_no_pulse got %b want 0", bus.frame_done); end
    bus.out_ack = 1;
    tick();
    bus.out_ack = 0;
    tests++; if (bus.frame_done !== 1'b1) begin fails++; $display("FAIL hold_swap_pulse got %b want 1", bus.frame_done); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL hold_release_ready got %b want 1", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL hold_out_valid got %b want 1", bus.out_valid); end
    tests++; if (bus.out_p !== mf_p) begin fails++; $display("FAIL hold_frame2_p got %h want %h", bus.out_p, mf_p); end
    tests++; if (bus.out_m !== mf_m) begin fails++; $display("FAIL hold_frame2_m got %h want %h", bus.out_m, mf_m); end
  endtask

  task automatic test_ack_same_cycle();
    for (int k = 0; k < NT; k++) begin
      drive_tile(1);
      bus.out_ack = k == NT - 1;
      tick();
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL same_in_ready tile %0d got %b want 1", k, bus.in_ready); end
    end
    bus.in_valid = 0; bus.out_ack = 0;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL same_out_valid got %b want 1", bus.out_valid); end
    tests++; if (bus.frame_done !== 1'b1) begin fails++; $display("FAIL same_pulse got %b want 1", bus.frame_done); end
    tests++; if (bus.out_p !== mf_p) begin fails++; $display("FAIL same_out_p got %h want %h", bus.out_p, mf_p); end
  endtask

  task automatic test_release();
    map_t stale;
    stale = bus.out_p;
    bus.out_ack = 1;
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL release_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.out_p !== mf_p) begin fails++; $display("FAIL release_stale got %h want %h", bus.out_p, mf_p); end
    tests++; if (mf_p !== stale) begin fails++; $display("FAIL release_model got %h want %h", mf_p, stale); end
    tick();
    bus.out_ack = 0;
    tests++; if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin fails++; $display("FAIL release_idle_ack got %b/%b want 0/0", bus.out_valid, bus.frame_done); end
  endtask

  task automatic test_toggle();
    int fd_at;
    fd_at = 0;
    for (int cyc = 1; cyc <= 2 * NT - 1; cyc++) begin
      drive_tile(cyc % 2 == 1);
      tick();
      if (bus.frame_done === 1'b1) fd_at = cyc;
      tests++; if (bus.frame_done !== mfd) begin fails++; $display("FAIL toggle_pulse cyc %0d got %b want %b", cyc, bus.frame_done, mfd); end
    end
    bus.in_valid = 0;
    tests++; if (fd_at !== 2 * NT - 1) begin fails++; $display("FAIL toggle_cycles got %0d want %0d", fd_at, 2 * NT - 1); end
    tests++; if (bus.out_p !== mf_p) begin fails++; $display("FAIL toggle_frame got %h want %h", bus.out_p, mf_p); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      drive_tile(1);
      tick();
    end
    bus.in_valid = 0;
    #2 nRST = 0;
    #1;
    model_reset();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.out_p !== '0 || bus.out_m !== '0) begin fails++; $display("FAIL mid_reset_map got %h/%h want 0", bus.out_p, bus.out_m); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready got %b want 1", bus.in_ready); end
    @(negedge CLK);
    nRST = 1;
    for (int k = 0; k < NT; k++) begin
      drive_tile(1);
      tick();
    end
    bus.in_valid = 0;
    tests++; if (bus.frame_done !== 1'b1) begin fails++; $display("FAIL mid_reset_done got %b want 1", bus.frame_done); end
    tests++; if (bus.out_p !== mf_p || bus.out_m !== mf_m) begin fails++; $display("FAIL mid_reset_frame got %h want %h", bus.out_p, mf_p); end
  endtask

`ifdef STOCH_UNPATCH_RESTART_EN
  task automatic test_restart();
    bus.out_ack = 1;
    tick();
    bus.out_ack = 0;
    for (int k = 0; k < 4; k++) begin
      drive_tile(1);
      tick();
    end
    drive_tile(1);
    restart = 1;
    #1;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL restart_ready got %b want 0", bus.in_ready); end
    tick();
    restart = 0;
    for (int k = 0; k < NT; k++) begin
      drive_tile(1);
      tick();
      tests++; if (bus.frame_done !== (k == NT - 1)) begin fails++; $display("FAIL restart_pulse tile %0d got %b", k, bus.frame_done); end
    end
    bus.in_valid = 0;
    tests++; if (bus.out_p !== mf_p || bus.out_m !== mf_m) begin fails++; $display("FAIL restart_frame got %h want %h", bus.out_p, mf_p); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_ack_same_cycle();
    test_release();
    test_toggle();
    test_reset_mid();
`ifdef STOCH_UNPATCH_RESTART_EN
    test_restart();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
